// File: rtl/mlx90640_fb_scaler_if.sv
// Control/status, framebuffer read port and pixel stream bundle for mlx90640_fb_scaler.
// The master modport is the scaler side; slave is the framebuffer/display side.
interface mlx90640_fb_scaler_if #(
    parameter int unsigned p_addrw = 10
);
    logic               i_start;
    logic               o_busy;
    logic               o_done;
    logic               o_fb_rd_valid;
    logic [p_addrw-1:0] o_fb_rd_addr;
    logic [16:0]        i_fb_rd_data;
    logic               o_pix_valid;
    logic [7:0]         o_pix_data;
    logic [4:0]         o_pix_x;
    logic [4:0]         o_pix_y;
    logic               o_pix_last;
    logic               i_pix_ready;
    logic [15:0]        o_frame_min;
    logic [15:0]        o_frame_max;

    modport master (
        input  i_start,
        input  i_fb_rd_data,
        input  i_pix_ready,
        output o_busy,
        output o_done,
        output o_fb_rd_valid,
        output o_fb_rd_addr,
        output o_pix_valid,
        output o_pix_data,
        output o_pix_x,
        output o_pix_y,
        output o_pix_last,
        output o_frame_min,
        output o_frame_max
    );

    modport slave (
        output i_start,
        output i_fb_rd_data,
        output i_pix_ready,
        input  o_busy,
        input  o_done,
        input  o_fb_rd_valid,
        input  o_fb_rd_addr,
        input  o_pix_valid,
        input  o_pix_data,
        input  o_pix_x,
        input  o_pix_y,
        input  o_pix_last,
        input  o_frame_min,
        input  o_frame_max
    );
endinterface

// File: rtl/mlx90640_fb_scaler.sv
// Scans the MLX90640 framebuffer, normalises raw pixels to 8-bit grey using the previous
// frame's min/max, and streams them out through a 2-entry FIFO with x/y/last sidebands.
module mlx90640_fb_scaler #(
    parameter int unsigned p_width  = 32,
    parameter int unsigned p_height = 24,
    parameter int unsigned p_addrw  = 10
) (
    input logic                  i_clk,
    input logic                  i_rst,
    mlx90640_fb_scaler_if.master bus
);
    localparam int unsigned        NumPix   = p_width * p_height;
    localparam logic [p_addrw-1:0] LastAddr = p_addrw'(NumPix - 1);
    localparam logic [p_addrw-1:0] RowLen   = p_addrw'(p_width);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StUpdate} state_e;

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] x;
        logic [4:0] y;
        logic       last;
    } pix_t;

    state_e             state_q, state_d;
    logic [p_addrw-1:0] rd_addr_q, rd_addr_d;
    logic               inflight_q;
    logic [p_addrw-1:0] inflight_addr_q;
    logic [1:0]         cnt_q, cnt_d;
    pix_t               head_q, head_d;
    pix_t               tail_q, tail_d;
    logic signed [15:0] acc_min_q, acc_min_d;
    logic signed [15:0] acc_max_q, acc_max_d;
    logic signed [15:0] ref_min_q, ref_min_d;
    logic signed [15:0] ref_max_q, ref_max_d;
    logic [3:0]         ref_shift_q, ref_shift_d;
    logic [15:0]        frame_min_q, frame_min_d;
    logic [15:0]        frame_max_q, frame_max_d;

    logic               pop;
    logic               push;
    logic               issue;
    logic [2:0]         pend;
    logic signed [15:0] raw;
    logic [16:0]        diff;
    logic [15:0]        shifted;
    logic [7:0]         norm_val;
    logic [16:0]        span;
    logic [3:0]         shift_calc;
    pix_t               new_pix;

    // Page bit is not needed; ref_max is held only alongside ref_min for completeness.
    logic unused_bits;
    assign unused_bits = ^{bus.i_fb_rd_data[0], ref_max_q};

    // Datapath: credit check, normalisation and shift search.
    always_comb begin
        pop   = (cnt_q != 2'd0) && bus.i_pix_ready;
        push  = inflight_q;
        // Occupancy counts a pop in this cycle so a full-rate stream never stalls.
        pend  = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (state_q == StScan) && (pend < 3'd2);

        raw     = signed'(bus.i_fb_rd_data[16:1]);
        diff    = {raw[15], raw} - {ref_min_q[15], ref_min_q};
        shifted = diff[15:0] >> ref_shift_q;
        if (diff[16]) begin
            norm_val = 8'd0;
        end else if (shifted > 16'd255) begin
            norm_val = 8'd255;
        end else begin
            norm_val = shifted[7:0];
        end

        new_pix.data = norm_val;
        new_pix.x    = 5'(inflight_addr_q % RowLen);
        new_pix.y    = 5'(inflight_addr_q / RowLen);
        new_pix.last = (inflight_addr_q == LastAddr);

        span       = {acc_max_q[15], acc_max_q} - {acc_min_q[15], acc_min_q};
        shift_calc = 4'd9;
        for (int s = 8; s >= 0; s--) begin
            if ((span >> s) <= 17'd255) shift_calc = 4'(s);
        end
    end

    // FSM next state and frame statistics.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        acc_min_d   = acc_min_q;
        acc_max_d   = acc_max_q;
        ref_min_d   = ref_min_q;
        ref_max_d   = ref_max_q;
        ref_shift_d = ref_shift_q;
        frame_min_d = frame_min_q;
        frame_max_d = frame_max_q;

        if (inflight_q) begin
            if (raw < acc_min_q) acc_min_d = raw;
            if (raw > acc_max_q) acc_max_d = raw;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    state_d   = StScan;
                    rd_addr_d = '0;
                    acc_min_d = 16'sh7FFF;
                    acc_max_d = 16'sh8000;
                end
            end
            StScan: begin
                if (issue) begin
                    if (rd_addr_q == LastAddr) begin
                        state_d = StDrain;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (!inflight_q && (cnt_q == 2'd0)) state_d = StUpdate;
            end
            StUpdate: begin
                ref_min_d   = acc_min_q;
                ref_max_d   = acc_max_q;
                ref_shift_d = shift_calc;
                frame_min_d = acc_min_q;
                frame_max_d = acc_max_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output FIFO: head drives the stream ports directly.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = new_pix;
                else               tail_d = new_pix;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) head_d = tail_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = new_pix;
                end else begin
                    head_d = new_pix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= StIdle;
            rd_addr_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            cnt_q           <= 2'd0;
            head_q          <= '0;
            tail_q          <= '0;
            acc_min_q       <= 16'sh7FFF;
            acc_max_q       <= 16'sh8000;
            ref_min_q       <= 16'sh0000;
            ref_max_q       <= 16'sh3FFF;
            ref_shift_q     <= 4'd6;
            frame_min_q     <= '0;
            frame_max_q     <= '0;
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            inflight_q      <= issue;
            inflight_addr_q <= issue ? rd_addr_q : inflight_addr_q;
            cnt_q           <= cnt_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            acc_min_q       <= acc_min_d;
            acc_max_q       <= acc_max_d;
            ref_min_q       <= ref_min_d;
            ref_max_q       <= ref_max_d;
            ref_shift_q     <= ref_shift_d;
            frame_min_q     <= frame_min_d;
            frame_max_q     <= frame_max_d;
        end
    end

    assign bus.o_busy        = (state_q != StIdle);
    assign bus.o_done        = (state_q == StUpdate);
    assign bus.o_fb_rd_valid = issue;
    assign bus.o_fb_rd_addr  = rd_addr_q;
    assign bus.o_pix_valid   = (cnt_q != 2'd0);
    assign bus.o_pix_data    = head_q.data;
    assign bus.o_pix_x       = head_q.x;
    assign bus.o_pix_y       = head_q.y;
    assign bus.o_pix_last    = head_q.last;
    assign bus.o_frame_min   = frame_min_q;
    assign bus.o_frame_max   = frame_max_q;
endmodule

// File: tb/tb_mlx90640_fb_scaler.sv
// Scoreboard bench for mlx90640_fb_scaler: a framebuffer model, a reference normaliser
// and an output monitor comparing every streamed pixel.
module tb_mlx90640_fb_scaler;
    localparam int NumPix = 768;

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] x;
        logic [4:0] y;
        logic       last;
    } exp_pix_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mlx90640_fb_scaler_if #(.p_addrw(10)) bus ();

    mlx90640_fb_scaler #(
        .p_width (32),
        .p_height(24),
        .p_addrw (10)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    // Framebuffer: one-cycle read latency, page bit taken from the address LSB.
    logic signed [15:0] mem [NumPix];
    logic [16:0]        rd_data_q = '0;
    always @(posedge clk) begin
        if (bus.o_fb_rd_valid) rd_data_q <= {mem[bus.o_fb_rd_addr], bus.o_fb_rd_addr[0]};
    end
    assign bus.i_fb_rd_data = rd_data_q;

    int n_checks = 0;
    int n_pass   = 0;

    exp_pix_t sb[$];
    exp_pix_t mon_e;
    logic [7:0] got_data [1024];
    int  issued, accepted, exp_addr, done_cnt, cyc;
    int  last_issue_cyc, done_cyc;
    int  ref_min_m   = 0;
    int  ref_shift_m = 6;
    int  fr_min_m, fr_max_m;
    bit  mon_en     = 1'b0;
    bit  ready_rand = 1'b0;
    bit  stalled;
    logic [19:0] held, cur;
    bit  pop;
    int  a;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int calc_shift(input int span);
        for (int s = 0; s <= 9; s++) begin
            if ((span >> s) <= 255) return s;
        end
        return 9;
    endfunction

    function automatic logic [7:0] norm(input int raw, input int rmin, input int sh);
        int d;
        d = raw - rmin;
        if (d < 0) return 8'd0;
        d = d >>> sh;
        if (d > 255) return 8'd255;
        return 8'(d);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_ctrl"}, {bus.o_busy, bus.o_done, bus.o_fb_rd_valid, bus.o_pix_valid,
                              bus.o_pix_last, bus.o_fb_rd_addr, bus.o_pix_data, bus.o_pix_x,
                              bus.o_pix_y}, 64'd0);
        check({tag, "_frame"}, {bus.o_frame_min, bus.o_frame_max}, 64'd0);
    endtask

    task automatic begin_frame();
        @(posedge clk);
        sb.delete();
        issued   = 0;
        accepted = 0;
        exp_addr = 0;
        done_cnt = 0;
        stalled  = 1'b0;
        fr_min_m = 32767;
        fr_max_m = -32768;
        for (int i = 0; i < NumPix; i++) begin
            if (int'(mem[i]) < fr_min_m) fr_min_m = int'(mem[i]);
            if (int'(mem[i]) > fr_max_m) fr_max_m = int'(mem[i]);
        end
        mon_en = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 bus.i_start = 1'b1;
        @(posedge clk);
        #2 bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 10000) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_done_seen"}, done_cnt != 0, 1);
        repeat (4) @(posedge clk);
        check({tag, "_pixels"}, accepted, NumPix);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_done_once"}, done_cnt, 1);
    endtask

    // Ready driver: held high or 30% random, changed just after each rising edge.
    initial begin
        bus.i_pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2 bus.i_pix_ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: samples on the falling edge.
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en && !rst) begin
                pop = bus.o_pix_valid && bus.i_pix_ready;
                cur = {bus.o_pix_valid, bus.o_pix_data, bus.o_pix_x, bus.o_pix_y, bus.o_pix_last};
                if (stalled) check("stall_hold", cur, held);
                stalled = bus.o_pix_valid && !bus.i_pix_ready;
                held    = cur;
                if (bus.o_fb_rd_valid) begin
                    check("rd_credit", (issued - accepted - int'(pop)) < 2, 1);
                    check("rd_addr", bus.o_fb_rd_addr, exp_addr);
                    a = int'(bus.o_fb_rd_addr);
                    mon_e.data = norm(int'(mem[a]), ref_min_m, ref_shift_m);
                    mon_e.x    = 5'(a % 32);
                    mon_e.y    = 5'(a / 32);
                    mon_e.last = (a == NumPix - 1);
                    sb.push_back(mon_e);
                    issued++;
                    exp_addr++;
                    if (a == NumPix - 1) last_issue_cyc = cyc;
                end
                if (pop) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("pixel", {bus.o_pix_data, bus.o_pix_x, bus.o_pix_y, bus.o_pix_last},
                              mon_e);
                    end
                    got_data[int'(bus.o_pix_x) + 32 * int'(bus.o_pix_y)] = bus.o_pix_data;
                    accepted++;
                end
                if (bus.o_done) begin
                    done_cnt++;
                    done_cyc    = cyc;
                    ref_min_m   = fr_min_m;
                    ref_shift_m = calc_shift(fr_max_m - fr_min_m);
                end
            end
        end
    end

    initial begin
        int n;
        bus.i_start = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset("reset");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_reset("idle");

        // Frame A: ramp data, reset refs (min 0, shift 6), latency checks.
        for (int i = 0; i < NumPix; i++) mem[i] = 16'(i);
        begin_frame();
        pulse_start();
        @(negedge clk);
        check("lat_c1", {bus.o_busy, bus.o_fb_rd_valid, bus.o_fb_rd_addr}, {1'b1, 1'b1, 10'd0});
        @(negedge clk);
        check("lat_c2_pixv", bus.o_pix_valid, 0);
        @(negedge clk);
        check("lat_c3_pixv", bus.o_pix_valid, 1);
        wait_done("A");
        check("A_done_latency", done_cyc - last_issue_cyc, 4);
        check("A_pix767", got_data[767], 8'd11);
        check("A_frame_min", bus.o_frame_min, 16'h0000);
        check("A_frame_max", bus.o_frame_max, 16'h02FF);
        check("A_busy_idle", bus.o_busy, 0);

        // Frame B: same data, refs now min 0, shift 2.
        begin_frame();
        pulse_start();
        wait_done("B");
        check("B_pix767", got_data[767], 8'd191);
        check("B_pix4", got_data[4], 8'd1);

        // Frames C/D: alternating -100/+100; D under random backpressure.
        for (int i = 0; i < NumPix; i++) mem[i] = (i % 2 == 1) ? 16'sd100 : -16'sd100;
        begin_frame();
        pulse_start();
        wait_done("C");
        check("C_frame_min", bus.o_frame_min, 16'hFF9C);
        ready_rand = 1'b1;
        begin_frame();
        pulse_start();
        wait_done("D");
        ready_rand = 1'b0;
        check("D_pix_neg", got_data[0], 8'd0);
        check("D_pix_pos", got_data[1], 8'd200);
        check("D_frame_min", bus.o_frame_min, 16'hFF9C);
        check("D_frame_max", bus.o_frame_max, 16'h0064);

        // Frame E: a start pulse mid-scan must be ignored.
        begin_frame();
        pulse_start();
        repeat (50) @(posedge clk);
        #2 bus.i_start = 1'b1;
        @(posedge clk);
        #2 bus.i_start = 1'b0;
        wait_done("E");

        // Frame F: reset after 300 accepted pixels.
        begin_frame();
        pulse_start();
        n = 0;
        while (accepted < 300 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("F_reached_300", accepted >= 300, 1);
        #3 mon_en = 1'b0;
        rst = 1'b1;
        #1 check_reset("abort");
        ref_min_m   = 0;
        ref_shift_m = 6;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Frame G: full frame after reset, using restored refs.
        begin_frame();
        pulse_start();
        wait_done("G");
        check("G_pix_pos", got_data[1], 8'd1);
        check("G_frame_min", bus.o_frame_min, 16'hFF9C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
